// File: rtl/conv_cfg_regs.sv
// Convolution layer configuration register bank.
// Holds BCFG1, BCFG2 and CPRM1 (16 bits each), written from the host
// command path and decoded into the named fields the convolution engines use.
// Register index follows addr_i: 0 = BCFG1, 1 = BCFG2, 2 = CPRM1, 3 = unmapped.
module conv_cfg_regs #(
  parameter logic [15:0] Bcfg1Reset = 16'h0001,
  parameter logic [15:0] Bcfg2Reset = 16'h0000,
  parameter logic [15:0] Cprm1Reset = 16'h0040
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic [9:0]  engine_count_o,
  output logic [3:0]  shift_low_o,
  output logic [13:0] matrix_size_o,
  output logic [1:0]  shift_high_o,
  output logic [5:0]  shift_amount_o,
  output logic        accumulate_o,
  output logic        save_to_buffer_o,
  output logic        save_to_ram_o,
  output logic [2:0]  padding_o,
  output logic [3:0]  stride_o
);

  localparam int NumRegs = 3;

  // Per-register writable masks; reserved bits are held at 0 by the mask
  // on both the reset and the write path, so they always read back as 0.
  localparam logic [NumRegs-1:0][15:0] RegMask = {
    16'h03FF,  // CPRM1: bits 15:10 reserved
    16'hFFFF,  // BCFG2: fully writable
    16'h3FFF   // BCFG1: bits 15:14 reserved
  };

  localparam logic [NumRegs-1:0][15:0] RegReset = {
    Cprm1Reset,
    Bcfg2Reset,
    Bcfg1Reset
  };

  // Current contents of all mapped registers, index = address.
  logic [NumRegs-1:0][15:0] regs_q;

  for (genvar gi = 0; gi < NumRegs; gi++) begin : gen_reg
    logic        wr_sel;
    logic [15:0] reg_q;
    logic [15:0] reg_d;

    // Only one register matches a given address, so address 3 selects none.
    assign wr_sel = we_i && (addr_i == 2'(gi));

    // Next-state: masked write data when selected, otherwise hold.
    always_comb begin
      reg_d = reg_q;
      if (wr_sel) begin
        reg_d = wdata_i & RegMask[gi];
      end
    end

    // Register update; reset takes priority over a simultaneous write.
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        reg_q <= RegReset[gi] & RegMask[gi];
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs_q[gi] = reg_q;
  end

  // Combinational readback of the addressed register; unmapped reads as 0.
  always_comb begin
    rdata_o = 16'h0000;
    case (addr_i)
      2'd0:    rdata_o = regs_q[0];
      2'd1:    rdata_o = regs_q[1];
      2'd2:    rdata_o = regs_q[2];
      default: rdata_o = 16'h0000;
    endcase
  end

  // Field decode: pure slices of the flops, no path from wdata_i.
  // Values are passed through unchecked; range checking is the consumer's job.
  assign engine_count_o   = regs_q[0][9:0];
  assign shift_low_o      = regs_q[0][13:10];
  assign matrix_size_o    = regs_q[1][13:0];
  assign shift_high_o     = regs_q[1][15:14];
  assign shift_amount_o   = {regs_q[1][15:14], regs_q[0][13:10]};
  assign accumulate_o     = regs_q[2][0];
  assign save_to_buffer_o = regs_q[2][1];
  assign save_to_ram_o    = regs_q[2][2];
  assign padding_o        = regs_q[2][5:3];
  assign stride_o         = regs_q[2][9:6];

endmodule

// File: tb/tb_conv_cfg_regs.sv
// Directed testbench for the convolution configuration register bank.
// Expected values are hand-derived from the register/field map.
module tb_conv_cfg_regs;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [15:0] wdata_i = 16'h0000;
  logic [15:0] rdata_o;
  logic [9:0]  engine_count_o;
  logic [3:0]  shift_low_o;
  logic [13:0] matrix_size_o;
  logic [1:0]  shift_high_o;
  logic [5:0]  shift_amount_o;
  logic        accumulate_o;
  logic        save_to_buffer_o;
  logic        save_to_ram_o;
  logic [2:0]  padding_o;
  logic [3:0]  stride_o;

  int errors = 0;
  int checks = 0;

  conv_cfg_regs dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .we_i             (we_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .rdata_o          (rdata_o),
    .engine_count_o   (engine_count_o),
    .shift_low_o      (shift_low_o),
    .matrix_size_o    (matrix_size_o),
    .shift_high_o     (shift_high_o),
    .shift_amount_o   (shift_amount_o),
    .accumulate_o     (accumulate_o),
    .save_to_buffer_o (save_to_buffer_o),
    .save_to_ram_o    (save_to_ram_o),
    .padding_o        (padding_o),
    .stride_o         (stride_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One write transaction: drive on the falling edge, commit on the rising edge.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk_i);
    we_i = 1'b1;
    addr_i = a;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    we_i = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp_v);
    addr_i = a;
    #1;
    check(tag, rdata_o, exp_v);
    $display("read  addr=%0d data=%h", a, rdata_o);
  endtask

  initial begin
    // Reset for one cycle.
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    check("rst_engine_count", 16'(engine_count_o), 16'd1);
    check("rst_matrix_size", 16'(matrix_size_o), 16'd0);
    check("rst_stride", 16'(stride_o), 16'd1);
    check("rst_padding", 16'(padding_o), 16'd0);
    check("rst_flags", 16'({accumulate_o, save_to_buffer_o, save_to_ram_o}), 16'd0);
    check("rst_shift_amount", 16'(shift_amount_o), 16'd0);
    rd("rst_rd0", 2'd0, 16'h0001);
    rd("rst_rd1", 2'd1, 16'h0000);
    rd("rst_rd2", 2'd2, 16'h0040);

    // Basic back-to-back writes to different registers.
    wr(2'd0, 16'h0002);
    check("basic_ec_latency", 16'(engine_count_o), 16'd2);
    wr(2'd1, 16'h0005);
    wr(2'd2, 16'h0040);
    check("basic_engine_count", 16'(engine_count_o), 16'd2);
    check("basic_matrix_size", 16'(matrix_size_o), 16'd5);
    check("basic_stride", 16'(stride_o), 16'd1);
    check("basic_shift_amount", 16'(shift_amount_o), 16'd0);
    check("basic_flags", 16'({accumulate_o, save_to_buffer_o, save_to_ram_o}), 16'd0);

    // Flag write.
    wr(2'd2, 16'h0045);
    check("flag_accumulate", 16'(accumulate_o), 16'd1);
    check("flag_save_ram", 16'(save_to_ram_o), 16'd1);
    check("flag_save_buf", 16'(save_to_buffer_o), 16'd0);
    check("flag_stride", 16'(stride_o), 16'd1);
    check("flag_padding", 16'(padding_o), 16'd0);

    // Shift split across BCFG1 and BCFG2.
    wr(2'd0, 16'h2C03);
    wr(2'd1, 16'h8007);
    check("shift_low", 16'(shift_low_o), 16'hB);
    check("shift_ec", 16'(engine_count_o), 16'd3);
    check("shift_high", 16'(shift_high_o), 16'd2);
    check("shift_matrix", 16'(matrix_size_o), 16'd7);
    check("shift_amount", 16'(shift_amount_o), 16'h2B);

    // Reserved bits.
    wr(2'd0, 16'hFFFF);
    rd("resv_rd0", 2'd0, 16'h3FFF);
    wr(2'd2, 16'hFFFF);
    rd("resv_rd2", 2'd2, 16'h03FF);
    check("resv_padding", 16'(padding_o), 16'd7);
    check("resv_stride", 16'(stride_o), 16'd15);
    check("resv_flags", 16'({accumulate_o, save_to_buffer_o, save_to_ram_o}), 16'h7);

    // Unmapped address: nothing changes, reads 0.
    wr(2'd3, 16'h1234);
    rd("unmap_rd3", 2'd3, 16'h0000);
    rd("unmap_rd0", 2'd0, 16'h3FFF);
    rd("unmap_rd1", 2'd1, 16'h8007);
    rd("unmap_rd2", 2'd2, 16'h03FF);

    // Same register back-to-back: last write wins.
    wr(2'd1, 16'h0011);
    wr(2'd1, 16'h0022);
    rd("last_wins_rd1", 2'd1, 16'h0022);

    // Reset beats a simultaneous write.
    @(negedge clk_i);
    rst_i = 1'b0;
    we_i = 1'b1;
    addr_i = 2'd0;
    wdata_i = 16'h0010;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    we_i = 1'b0;
    $display("reset+write addr=0 data=0010");
    check("rstprio_engine_count", 16'(engine_count_o), 16'd1);
    check("rstprio_matrix", 16'(matrix_size_o), 16'd0);
    check("rstprio_stride", 16'(stride_o), 16'd1);
    rd("rstprio_rd0", 2'd0, 16'h0001);

    // Hold: registers keep their value with we_i low.
    wr(2'd1, 16'h1357);
    addr_i = 2'd1;
    wdata_i = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      check("hold_rd1", rdata_o, 16'h1357);
      check("hold_engine_count", 16'(engine_count_o), 16'd1);
      check("hold_stride", 16'(stride_o), 16'd1);
      check("hold_shift_amount", 16'(shift_amount_o), 16'h00);
    end
    $display("hold 20 cycles addr=1 data=%h", rdata_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
